// File: rtl/mem_line_master.sv
// Cache-line initiator for the main-memory word/burst interface.
// Fills collect a 4-word burst into a 128-bit line; writebacks stream the line out one word per ready beat.
module mem_line_master #(
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         line_req,
    input  logic         line_rw,
    input  logic [31:0]  line_addr,
    input  logic [127:0] line_wdata,
    output logic         line_busy,
    output logic         line_done,
    output logic         line_err,
    output logic [127:0] line_rdata,
    output logic         mem_req,
    output logic         mem_rw,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [1:0]      LAST_BEAT  = 2'(LINE_WORDS - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    beat_q, beat_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [127:0]  wbuf_q, wbuf_d;
    logic [127:0]  rdata_q, rdata_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_q, req_d;
    logic          rw_q, rw_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        timer_d = timer_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (line_req) begin
                    addr_d  = line_addr & 32'hFFFF_FFF0;
                    rw_d    = line_rw;
                    wbuf_d  = line_wdata;
                    wdata_d = line_wdata[31:0];
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    beat_d  = 2'd0;
                    timer_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ, S_XFER: begin
                if (mem_ready) begin
                    timer_d = '0;
                    req_d   = 1'b0;
                    beat_d  = beat_q + 2'd1;
                    if (!rw_q) begin
                        rdata_d[{beat_q, 5'd0} +: 32] = mem_rdata;
                    end else if (beat_q != LAST_BEAT) begin
                        // next word is presented only after the current one has been taken
                        wdata_d = wbuf_q[{beat_d, 5'd0} +: 32];
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_XFER;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            timer_q <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            timer_q <= timer_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign line_busy  = busy_q;
    assign line_done  = done_q;
    assign line_err   = err_q;
    assign line_rdata = rdata_q;
    assign mem_req    = req_q;
    assign mem_rw     = rw_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_line_master.sv
// Bench for mem_line_master: a behavioural word memory answers bursts with configurable latency and spacing.
module tb_mem_line_master;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         line_req = 1'b0;
    logic         line_rw = 1'b0;
    logic [31:0]  line_addr = '0;
    logic [127:0] line_wdata = '0;
    logic         line_busy, line_done, line_err;
    logic [127:0] line_rdata;
    logic         mem_req, mem_rw;
    logic [31:0]  mem_addr, mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem [0:2047];
    int beat_cyc[$];
    int lat_cfg = 2;
    int gap_min = 1;
    int gap_max = 1;
    bit mem_mute = 1'b0;
    bit noise = 1'b0;

    int   rs_st = 0, rs_cnt = 0, rs_bt = 0, rs_base = 0;
    logic rs_rw = 1'b0;

    mem_line_master dut (
        .clk        (clk),
        .reset      (reset),
        .line_req   (line_req),
        .line_rw    (line_rw),
        .line_addr  (line_addr),
        .line_wdata (line_wdata),
        .line_busy  (line_busy),
        .line_done  (line_done),
        .line_err   (line_err),
        .line_rdata (line_rdata),
        .mem_req    (mem_req),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] a);
        int b;
        b = int'(a[12:4]) * 4;
        return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
    endfunction

    // Memory side: sees mem_req, waits lat_cfg cycles, then gives 4 beats spaced by gap_min..gap_max idle cycles.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            tick();
            mem_ready = 1'b0;
            if (reset) begin
                rs_st = 0;
            end else if (rs_st == 0) begin
                if (mem_req && !mem_mute) begin
                    rs_base = int'(mem_addr[12:2]);
                    rs_rw   = mem_rw;
                    rs_bt   = 0;
                    rs_cnt  = lat_cfg;
                    rs_st   = 1;
                end else if (noise && !mem_req) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
            if (!reset && rs_st == 1) begin
                if (rs_cnt == 0) begin
                    mem_ready = 1'b1;
                    if (!rs_rw) mem_rdata = mem[rs_base + rs_bt];
                    else        mem[rs_base + rs_bt] = mem_wdata;
                    beat_cyc.push_back(cyc);
                    rs_bt++;
                    if (rs_bt == 4) rs_st = 0;
                    else rs_cnt = int'($urandom_range(gap_max, gap_min));
                end else begin
                    rs_cnt--;
                end
            end
        end
    end

    task automatic do_line(input logic rw, input logic [31:0] addr, input logic [127:0] wd,
                           output int done_rel, output int t0);
        logic [127:0] exp_rd;
        logic [31:0]  base;
        int n;
        base   = addr & 32'hFFFF_FFF0;
        exp_rd = line_of(base);
        beat_cyc.delete();
        line_rw = rw; line_addr = addr; line_wdata = wd; line_req = 1'b1;
        tick();
        line_req = 1'b0;
        t0 = cyc;
        checks++;
        if (line_busy !== 1'b1 || mem_req !== 1'b1) begin
            errors++; $display("FAIL accept busy/req got %b%b required 11", line_busy, mem_req);
        end
        checks++;
        if (mem_addr !== base || mem_rw !== rw) begin
            errors++; $display("FAIL req_addr_rw got %h/%b required %h/%b", mem_addr, mem_rw, base, rw);
        end
        if (rw) begin
            checks++;
            if (mem_wdata !== wd[31:0]) begin
                errors++; $display("FAIL first_wdata got %h required %h", mem_wdata, wd[31:0]);
            end
        end
        n = 0;
        while (line_done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        done_rel = cyc - t0 + 1;
        checks++;
        if (line_done !== 1'b1) begin
            errors++; $display("FAIL done_wait got %b required 1 within 300 cycles", line_done);
        end
        checks++;
        if (line_err !== 1'b0 || line_busy !== 1'b0) begin
            errors++; $display("FAIL done_flags err/busy got %b%b required 00", line_err, line_busy);
        end
        checks++;
        if (beat_cyc.size() != 4) begin
            errors++; $display("FAIL beat_count got %0d required 4", beat_cyc.size());
        end else if (cyc != beat_cyc[3] + 1) begin
            errors++; $display("FAIL done_latency got cycle %0d required %0d", cyc, beat_cyc[3] + 1);
        end
        checks++;
        if (!rw && line_rdata !== exp_rd) begin
            errors++; $display("FAIL fill_data got %h required %h", line_rdata, exp_rd);
        end else if (rw && line_of(base) !== wd) begin
            errors++; $display("FAIL wb_memory got %h required %h", line_of(base), wd);
        end
        tick();
        checks++;
        if (line_done !== 1'b0 || line_err !== 1'b0 || (!rw && line_rdata !== exp_rd)) begin
            errors++; $display("FAIL done_pulse done/err got %b%b rdata %h required 00 %h",
                               line_done, line_err, line_rdata, exp_rd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        line_req = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mem_req, mem_rw, mem_addr, mem_wdata, line_busy, line_done, line_err, line_rdata} !== '0) begin
            errors++; $display("FAIL reset_values got req=%b rw=%b addr=%h busy=%b done=%b required all 0",
                               mem_req, mem_rw, mem_addr, line_busy, line_done);
        end
        line_req = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ({mem_req, mem_rw, mem_addr, mem_wdata, line_busy, line_done, line_err, line_rdata} !== '0) begin
            errors++; $display("FAIL post_reset_idle got req=%b busy=%b done=%b required 0 0 0",
                               mem_req, line_busy, line_done);
        end
    endtask

    task automatic test_ref_fill();
        int d, t0;
        lat_cfg = 2; gap_min = 1; gap_max = 1; noise = 1'b0;
        do_line(1'b0, 32'h0000_1230, '0, d, t0);
        checks++;
        if (line_rdata !== 128'h3F3E3D3C_3B3A3938_37363534_33323130) begin
            errors++; $display("FAIL ref_fill_data got %h required 3f3e..3130", line_rdata);
        end
        checks++;
        if (d != 10) begin
            errors++; $display("FAIL ref_done_cycle got %0d required 10", d);
        end
        checks++;
        if (beat_cyc.size() != 4 || beat_cyc[0] - t0 + 1 != 3 || beat_cyc[1] - t0 + 1 != 5 ||
            beat_cyc[2] - t0 + 1 != 7 || beat_cyc[3] - t0 + 1 != 9) begin
            errors++; $display("FAIL ref_beat_cycles got first %0d required 3,5,7,9",
                               beat_cyc.size() > 0 ? beat_cyc[0] - t0 + 1 : -1);
        end
    endtask

    task automatic test_writeback();
        int d, t0;
        lat_cfg = 1; gap_min = 0; gap_max = 2; noise = 1'b1;
        do_line(1'b1, 32'h0000_0100, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, d, t0);
        checks++;
        if (mem[64] !== 32'hAAAAAAAA || mem[65] !== 32'hBBBBBBBB ||
            mem[66] !== 32'hCCCCCCCC || mem[67] !== 32'hDDDDDDDD) begin
            errors++; $display("FAIL wb_words got %h %h %h %h required aaaaaaaa bbbbbbbb cccccccc dddddddd",
                               mem[64], mem[65], mem[66], mem[67]);
        end
        gap_max = 0;
        do_line(1'b1, 32'h0000_0110, 128'h44444444_33333333_22222222_11111111, d, t0);
        checks++;
        if (mem[68] !== 32'h11111111 || mem[71] !== 32'h44444444) begin
            errors++; $display("FAIL wb_b2b_words got %h %h required 11111111 44444444", mem[68], mem[71]);
        end
        noise = 1'b0;
    endtask

    task automatic test_unaligned();
        int d, t0;
        lat_cfg = 3; gap_min = 0; gap_max = 3;
        do_line(1'b0, 32'h0000_004C, '0, d, t0);
        checks++;
        if (line_rdata !== 128'h4F4E4D4C_4B4A4948_47464544_43424140) begin
            errors++; $display("FAIL unaligned_data got %h required 4f4e..4140", line_rdata);
        end
    endtask

    task automatic test_held();
        logic [31:0]  a, b;
        logic [127:0] w, exp_a;
        int t0, n, bad;
        lat_cfg = 2; gap_min = 1; gap_max = 1; noise = 1'b0;
        a = 32'h0000_0300; b = 32'h0000_0340;
        w = {$urandom, $urandom, $urandom, $urandom};
        exp_a = line_of(a);
        line_rw = 1'b0; line_addr = a; line_wdata = '0; line_req = 1'b1;
        tick();
        t0 = cyc; n = 0; bad = 0;
        while (line_done !== 1'b1 && n < 100) begin
            if (cyc - t0 + 1 == 4) begin
                line_rw = 1'b1; line_addr = b; line_wdata = w;
            end
            if (mem_addr !== a || mem_rw !== 1'b0) bad++;
            tick();
            n++;
        end
        checks++;
        if (bad != 0 || line_done !== 1'b1) begin
            errors++; $display("FAIL held_first bad=%0d done=%b required 0 1", bad, line_done);
        end
        checks++;
        if (line_rdata !== exp_a) begin
            errors++; $display("FAIL held_fill_data got %h required %h", line_rdata, exp_a);
        end
        tick();
        checks++;
        if (line_busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL held_gap busy/req got %b%b required 00", line_busy, mem_req);
        end
        tick();
        line_req = 1'b0;
        checks++;
        if (line_busy !== 1'b1 || mem_addr !== b || mem_rw !== 1'b1 || mem_wdata !== w[31:0]) begin
            errors++; $display("FAIL held_second got busy=%b addr=%h rw=%b required 1 %h 1", line_busy, mem_addr, mem_rw, b);
        end
        repeat (2) tick();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        n = 0;
        while (line_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (line_done !== 1'b1 || line_of(b) !== w) begin
            errors++; $display("FAIL held_wb got done=%b mem=%h required 1 %h", line_done, line_of(b), w);
        end
        bad = 0;
        repeat (6) begin
            tick();
            if (line_busy !== 1'b0 || mem_req !== 1'b0 || line_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL not_queued got %0d busy cycles required 0", bad);
        end
    endtask

    task automatic test_timeout();
        int t0, bad, d, t1;
        mem_mute = 1'b1; noise = 1'b0;
        line_rw = 1'b0; line_addr = 32'h0000_0500; line_req = 1'b1;
        tick();
        line_req = 1'b0;
        t0 = cyc; bad = 0;
        while (cyc - t0 + 1 < 65) begin
            if (mem_req !== 1'b1 || line_done !== 1'b0 || line_err !== 1'b0 || line_busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL timeout_wait got %0d bad cycles required 0", bad);
        end
        checks++;
        if (mem_req !== 1'b0 || line_err !== 1'b1 || line_done !== 1'b1 || line_busy !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse req/err/done/busy got %b%b%b%b required 0110",
                               mem_req, line_err, line_done, line_busy);
        end
        tick();
        checks++;
        if (line_err !== 1'b0 || line_done !== 1'b0) begin
            errors++; $display("FAIL timeout_one_cycle err/done got %b%b required 00", line_err, line_done);
        end
        mem_mute = 1'b0;
        lat_cfg = 2; gap_min = 0; gap_max = 1;
        do_line(1'b1, 32'h0000_0600, {$urandom, $urandom, $urandom, $urandom}, d, t1);
    endtask

    task automatic test_reset_mid();
        int t0, bad, d, t1;
        lat_cfg = 2; gap_min = 1; gap_max = 1; noise = 1'b0;
        beat_cyc.delete();
        line_rw = 1'b0; line_addr = 32'h0000_0700; line_req = 1'b1;
        tick();
        line_req = 1'b0;
        t0 = cyc;
        while (cyc - t0 + 1 < 6) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_rw, mem_addr, mem_wdata, line_busy, line_done, line_err, line_rdata} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs got req=%b addr=%h busy=%b rdata=%h required 0",
                               mem_req, mem_addr, line_busy, line_rdata);
        end
        tick();
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            tick();
            if (line_done !== 1'b0 || line_busy !== 1'b0 || mem_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reset_mid_quiet got %0d active cycles required 0", bad);
        end
        do_line(1'b0, 32'h0000_0700, '0, d, t1);
    endtask

    task automatic test_random();
        int d, t0;
        logic rw;
        logic [31:0] addr;
        noise = 1'b1; gap_min = 0; gap_max = 3;
        for (int i = 0; i < 24; i++) begin
            lat_cfg = int'($urandom_range(1, 3));
            rw = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 32'h1FFF);
            do_line(rw, addr, {$urandom, $urandom, $urandom, $urandom}, d, t0);
            repeat ($urandom_range(0, 2)) tick();
        end
        noise = 1'b0;
    endtask

    initial begin
        for (int w = 0; w < 2048; w++)
            mem[w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        test_reset();
        test_ref_fill();
        test_writeback();
        test_unaligned();
        test_held();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
